// File: rtl/uc_rr_arbiter_pkg.sv
// rtl/uc_rr_arbiter_pkg.sv - literal types and helpers shared by the unit-clause arbiter and its users
package uc_pkg;

    localparam int UC_LENGTH = 1024;
    localparam int VAR_W     = $clog2(UC_LENGTH);
    localparam int LIT_W     = VAR_W + 1;

    typedef struct packed {
        logic             sign;
        logic [VAR_W-1:0] vidx;
    } lit_t;

    function automatic lit_t lit_neg(lit_t l);
        lit_t r;
        r      = l;
        r.sign = ~l.sign;
        return r;
    endfunction

    function automatic logic [VAR_W-1:0] lit_var(lit_t l);
        return l.vidx;
    endfunction

endpackage

// File: rtl/uc_rr_pick.sv
// rtl/uc_rr_pick.sv - combinational round-robin picker with optional fixed priority for requester 0
module uc_rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               prio_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    function automatic int wrap_idx(int base, int k);
        int s;
        s = base + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    always_comb begin
        winner = '0;
        any    = 1'b0;
        // Scan from the far end so the requester closest to rr_ptr is assigned last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(rr_ptr), k)]) begin
                winner = IDX_W'(wrap_idx(int'(rr_ptr), k));
                any    = 1'b1;
            end
        end
        if (prio_en && req[0]) begin
            winner = '0;
            any    = 1'b1;
        end
        grant = any ? (NUM_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/uc_rr_arbiter.sv
// rtl/uc_rr_arbiter.sv - merges memory and engine unit literals into one buffered stream
// Optional conflict detection is enabled by defining UC_ARB_CONFLICT_EN.
module uc_rr_arbiter #(
    parameter int NUM_ENG   = 4,
    parameter int UC_LENGTH = uc_pkg::UC_LENGTH,
    parameter int VAR_W     = $clog2(UC_LENGTH),
    parameter int LIT_W     = VAR_W + 1,
    parameter int BUF_DEPTH = 8,
    parameter int MEM_PRIO  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            mem_valid,
    input  logic [LIT_W-1:0]                mem_lit,
    output logic                            mem_ready,
    input  logic [NUM_ENG-1:0]              eng_valid,
    input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng_lit,
    output logic [NUM_ENG-1:0]              eng_ready,
    output logic                            out_valid,
    output logic [LIT_W-1:0]                out_lit,
    input  logic                            out_ready,
    output logic [$clog2(BUF_DEPTH):0]      count,
    output logic                            conflict,
    output logic [VAR_W-1:0]                conflict_var
);

    localparam int NUM_REQ = NUM_ENG + 1;
    localparam int RR_W    = $clog2(NUM_REQ);
    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [LIT_W-1:0]   storage_q [BUF_DEPTH];
    logic [LIT_W-1:0]   storage_d [BUF_DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RR_W-1:0]    rr_q, rr_d;

    logic [LIT_W-1:0]   req_lit [NUM_REQ];
    logic [NUM_REQ-1:0] pick_grant;
    logic [RR_W-1:0]    winner;
    logic               pick_any;
    logic               pop, space, push;
    logic [LIT_W-1:0]   push_lit;

    uc_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(RR_W)) u_pick (
        .req     ({eng_valid, mem_valid}),
        .rr_ptr  (rr_q),
        .prio_en (MEM_PRIO != 0),
        .grant   (pick_grant),
        .winner  (winner),
        .any     (pick_any)
    );

    always_comb begin
        req_lit[0] = mem_lit;
        for (int i = 0; i < NUM_ENG; i++) begin
            req_lit[i+1] = eng_lit[i];
        end
    end

    assign out_valid = (count_q != '0);
    assign out_lit   = storage_q[head_q];
    assign count     = count_q;
    assign pop       = out_valid & out_ready;
    assign space     = (count_q < CNT_W'(BUF_DEPTH)) | pop;
    // rst gates the grant so no ready leaks out while the block is held in reset.
    assign push      = pick_any & space & ~flush & rst;
    assign push_lit  = req_lit[winner];
    assign {eng_ready, mem_ready} = push ? pick_grant : '0;

    always_comb begin
        storage_d = storage_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rr_d      = rr_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            rr_d    = '0;
        end else begin
            if (push) begin
                storage_d[tail_q] = push_lit;
                tail_d            = tail_q + 1'b1;
                if (!(MEM_PRIO != 0 && winner == '0)) begin
                    rr_d = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
        end else begin
            storage_q <= storage_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
        end
    end

`ifdef UC_ARB_CONFLICT_EN
    logic             conflict_q, conflict_d;
    logic [VAR_W-1:0] conflict_var_q, conflict_var_d;
    logic             hit;

    // The head entry leaving this cycle no longer counts as buffered.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < BUF_DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && !(k == 0 && pop) &&
                (storage_q[head_q + PTR_W'(k)][LIT_W-1] != push_lit[LIT_W-1]) &&
                (storage_q[head_q + PTR_W'(k)][VAR_W-1:0] == push_lit[VAR_W-1:0])) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        conflict_d     = conflict_q;
        conflict_var_d = conflict_var_q;
        if (flush) begin
            conflict_d     = 1'b0;
            conflict_var_d = '0;
        end else if (push && hit && !conflict_q) begin
            conflict_d     = 1'b1;
            conflict_var_d = push_lit[VAR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q     <= 1'b0;
            conflict_var_q <= '0;
        end else begin
            conflict_q     <= conflict_d;
            conflict_var_q <= conflict_var_d;
        end
    end

    assign conflict     = conflict_q;
    assign conflict_var = conflict_var_q;
`else
    assign conflict     = 1'b0;
    assign conflict_var = '0;
`endif

endmodule

// File: tb/tb_uc_rr_arbiter.sv
// tb/tb_uc_rr_arbiter.sv - self-checking bench for uc_rr_arbiter with a queue-based reference model
module tb_uc_rr_arbiter;

`ifdef UC_ARB_CONFLICT_EN
    localparam bit EXP_C = 1'b1;
`else
    localparam bit EXP_C = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, flush, mem_valid, out_ready;
    logic [10:0]      mem_lit;
    logic [3:0]       eng_valid;
    logic [3:0][10:0] eng_lit;

    logic             mem_ready, out_valid, conflict;
    logic [3:0]       eng_ready, count;
    logic [10:0]      out_lit;
    logic [9:0]       conflict_var;

    logic             p_mem_ready, p_out_valid, p_conflict;
    logic [3:0]       p_eng_ready, p_count;
    logic [10:0]      p_out_lit;
    logic [9:0]       p_conflict_var;

    int n_checks = 0;
    int n_fail   = 0;

    uc_pkg::lit_t mq[$];
    int           m_rr;
    int           m_last;
    bit           m_c;
    logic [9:0]   m_cv;

    always #5 clk = ~clk;

    uc_rr_arbiter #(.NUM_ENG(4), .UC_LENGTH(1024), .BUF_DEPTH(8), .MEM_PRIO(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_ready(mem_ready),
        .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_ready(eng_ready),
        .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
        .count(count), .conflict(conflict), .conflict_var(conflict_var)
    );

    uc_rr_arbiter #(.NUM_ENG(4), .UC_LENGTH(1024), .BUF_DEPTH(8), .MEM_PRIO(1)) dut_p (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_ready(p_mem_ready),
        .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_ready(p_eng_ready),
        .out_valid(p_out_valid), .out_lit(p_out_lit), .out_ready(out_ready),
        .count(p_count), .conflict(p_conflict), .conflict_var(p_conflict_var)
    );

    function automatic int model_pick(int rr, logic [4:0] req);
        for (int k = 0; k < 5; k++) begin
            if (req[(rr + k) % 5]) return (rr + k) % 5;
        end
        return -1;
    endfunction

    function automatic logic [10:0] rr_lit(int idx);
        return (idx == 0) ? 11'h011 : 11'(32'h020 + idx - 1);
    endfunction

    task automatic do_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        mem_valid = 1'b0; mem_lit = '0; eng_valid = '0; eng_lit = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mq.delete(); m_rr = 0; m_last = -1; m_c = 1'b0; m_cv = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        mem_valid = 1'b1; mem_lit = 11'h123; eng_valid = 4'hF;
        for (int i = 0; i < 4; i++) eng_lit[i] = 11'(32'h040 + i);
        @(negedge clk); #1;
        n_checks++; if ({eng_ready, mem_ready} !== 5'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 00000", {eng_ready, mem_ready}); end
        n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL reset_out: valid=%b count=%0d want 0/0", out_valid, count); end
        n_checks++; if (out_lit !== 11'h000 || conflict !== 1'b0 || conflict_var !== 10'h0) begin n_fail++; $display("FAIL reset_regs: lit=%h c=%b cv=%h want 0", out_lit, conflict, conflict_var); end
        @(negedge clk);
        rst = 1'b1; #1;
        n_checks++; if ({eng_ready, mem_ready} !== 5'b00001) begin n_fail++; $display("FAIL first_grant: got %b want 00001", {eng_ready, mem_ready}); end
        @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_lit !== 11'h123 || count !== 4'd1) begin n_fail++; $display("FAIL first_visible: valid=%b lit=%h count=%0d want 1/123/1", out_valid, out_lit, count); end
        n_checks++; if ({eng_ready, mem_ready} !== 5'b00010) begin n_fail++; $display("FAIL rr_after_mem: got %b want 00010", {eng_ready, mem_ready}); end
        rst = 1'b0; #1;
        n_checks++; if (count !== 4'd0 || out_valid !== 1'b0 || {eng_ready, mem_ready} !== 5'b0) begin n_fail++; $display("FAIL async_reset: count=%0d valid=%b rdy=%b want 0/0/0", count, out_valid, {eng_ready, mem_ready}); end
    endtask

    task automatic test_round_robin();
        int tally[5];
        do_reset();
        for (int i = 0; i < 5; i++) tally[i] = 0;
        mem_valid = 1'b1; mem_lit = rr_lit(0); eng_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) eng_lit[i] = rr_lit(i + 1);
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++; if ({eng_ready, mem_ready} !== 5'(1 << (c % 5))) begin n_fail++; $display("FAIL rr_grant c=%0d: got %b want %b", c, {eng_ready, mem_ready}, 5'(1 << (c % 5))); end
            for (int r = 0; r < 5; r++) if ({eng_ready, mem_ready}[r]) tally[r]++;
            if (c > 0) begin
                n_checks++; if (out_lit !== rr_lit((c - 1) % 5) || count !== 4'd1) begin n_fail++; $display("FAIL rr_stream c=%0d: lit=%h count=%0d want %h/1", c, out_lit, count, rr_lit((c - 1) % 5)); end
            end
            @(negedge clk);
        end
        n_checks++; if (tally[0] != 2 || tally[1] != 2 || tally[2] != 2 || tally[3] != 2 || tally[4] != 2) begin n_fail++; $display("FAIL rr_fair: %0d %0d %0d %0d %0d want 2 each", tally[0], tally[1], tally[2], tally[3], tally[4]); end
    endtask

    task automatic test_full();
        logic [10:0] exp_l;
        do_reset();
        mem_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_lit = 11'(32'h100 + k); #1;
            n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready k=%0d: got %b want 1", k, mem_ready); end
            @(negedge clk);
        end
        mem_valid = 1'b0; eng_valid = 4'b0001; eng_lit[0] = 11'h2AA; #1;
        n_checks++; if (count !== 4'd8 || {eng_ready, mem_ready} !== 5'b0 || out_lit !== 11'h100) begin n_fail++; $display("FAIL full_hold: count=%0d rdy=%b lit=%h want 8/00000/100", count, {eng_ready, mem_ready}, out_lit); end
        @(negedge clk);
        out_ready = 1'b1; #1;
        n_checks++; if (eng_ready !== 4'b0001 || mem_ready !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: rdy=%b want 00010", {eng_ready, mem_ready}); end
        @(negedge clk);
        eng_valid = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_l = (k < 7) ? 11'(32'h101 + k) : 11'h2AA;
            if (k == 0) begin
                n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", count); end
            end
            n_checks++; if (out_valid !== 1'b1 || out_lit !== exp_l) begin n_fail++; $display("FAIL drain k=%0d: valid=%b lit=%h want 1/%h", k, out_valid, out_lit, exp_l); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL drained: valid=%b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_mem_prio();
        do_reset();
        out_ready = 1'b1; mem_valid = 1'b1; mem_lit = 11'h050;
        eng_valid = 4'b0010; eng_lit[1] = 11'h061;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (p_mem_ready !== 1'b1 || p_eng_ready !== 4'b0000) begin n_fail++; $display("FAIL prio_mem c=%0d: rdy=%b want 00001", c, {p_eng_ready, p_mem_ready}); end
            @(negedge clk);
        end
        mem_valid = 1'b0; #1;
        n_checks++; if (p_eng_ready !== 4'b0010 || p_mem_ready !== 1'b0 || p_out_lit !== 11'h050) begin n_fail++; $display("FAIL prio_eng1: rdy=%b lit=%h want 00100/050", {p_eng_ready, p_mem_ready}, p_out_lit); end
        @(negedge clk); #1;
        n_checks++; if (p_out_lit !== 11'h061 || p_count !== 4'd1 || p_out_valid !== 1'b1 || p_conflict !== 1'b0 || p_conflict_var !== 10'h0) begin n_fail++; $display("FAIL prio_out: lit=%h count=%0d valid=%b c=%b want 061/1/1/0", p_out_lit, p_count, p_out_valid, p_conflict); end
    endtask

    task automatic test_flush();
        logic [10:0] seq [3];
        seq[0] = 11'h005; seq[1] = 11'h00A; seq[2] = 11'h003;
        do_reset();
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_lit = seq[k];
            @(negedge clk);
        end
        mem_lit = 11'h007; flush = 1'b1; #1;
        n_checks++; if ({eng_ready, mem_ready} !== 5'b0 || count !== 4'd3) begin n_fail++; $display("FAIL flush_noready: rdy=%b count=%0d want 00000/3", {eng_ready, mem_ready}, count); end
        @(negedge clk);
        flush = 1'b0; #1;
        n_checks++; if (count !== 4'd0 || out_valid !== 1'b0 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL flush_clear: count=%0d valid=%b mrdy=%b want 0/0/1", count, out_valid, mem_ready); end
        @(negedge clk);
        mem_valid = 1'b0; #1;
        n_checks++; if (out_valid !== 1'b1 || out_lit !== 11'h007 || count !== 4'd1) begin n_fail++; $display("FAIL flush_next: valid=%b lit=%h count=%0d want 1/007/1", out_valid, out_lit, count); end
    endtask

    task automatic test_conflict();
        do_reset();
        mem_valid = 1'b1; mem_lit = 11'h005;
        @(negedge clk);
        mem_valid = 1'b0; eng_valid = 4'b0100; eng_lit[2] = 11'h405; #1;
        n_checks++; if (eng_ready !== 4'b0100) begin n_fail++; $display("FAIL conf_grant: got %b want 0100", eng_ready); end
        @(negedge clk);
        eng_valid = 4'b0000; #1;
        n_checks++; if (count !== 4'd2 || conflict !== EXP_C || conflict_var !== (EXP_C ? 10'd5 : 10'd0)) begin n_fail++; $display("FAIL conf_set: count=%0d c=%b cv=%h want 2/%b/%h", count, conflict, conflict_var, EXP_C, EXP_C ? 10'd5 : 10'd0); end
        mem_valid = 1'b1; mem_lit = 11'h003;
        @(negedge clk);
        mem_lit = 11'h403;
        @(negedge clk);
        mem_valid = 1'b0; #1;
        n_checks++; if (count !== 4'd4 || conflict !== EXP_C || conflict_var !== (EXP_C ? 10'd5 : 10'd0)) begin n_fail++; $display("FAIL conf_sticky: count=%0d c=%b cv=%h want 4/%b/%h", count, conflict, conflict_var, EXP_C, EXP_C ? 10'd5 : 10'd0); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; #1;
        n_checks++; if (conflict !== 1'b0 || conflict_var !== 10'd0 || count !== 4'd0) begin n_fail++; $display("FAIL conf_flush: c=%b cv=%h count=%0d want 0/0/0", conflict, conflict_var, count); end
    endtask

    task automatic test_random();
        logic [4:0]  req, exp_rdy;
        logic [10:0] lit_w, new_l;
        int          n, w;
        bit          pop_e, space, g, hit, new_v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 5; r++) begin
                if (!(r == 0 ? mem_valid : eng_valid[r-1]) || m_last == r) begin
                    new_v = ($urandom_range(0, 2) != 0);
                    new_l = {1'($urandom_range(0, 1)), 10'($urandom_range(0, 7))};
                    if (r == 0) begin mem_valid = new_v; mem_lit = new_l; end
                    else begin eng_valid[r-1] = new_v; eng_lit[r-1] = new_l; end
                end
            end
            flush = ($urandom_range(0, 24) == 0);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            req = {eng_valid, mem_valid};
            n = mq.size();
            pop_e = (n != 0) && out_ready;
            space = (n < 8) || pop_e;
            w = model_pick(m_rr, req);
            g = !flush && space && (w >= 0);
            exp_rdy = g ? 5'(1 << w) : 5'd0;
            n_checks++; if ({eng_ready, mem_ready} !== exp_rdy) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b want %b", c, {eng_ready, mem_ready}, exp_rdy); end
            n_checks++; if (out_valid !== (n != 0) || count !== 4'(n)) begin n_fail++; $display("FAIL rand_occ c=%0d: valid=%b count=%0d want %0d", c, out_valid, count, n); end
            if (n != 0) begin
                n_checks++; if (out_lit !== mq[0]) begin n_fail++; $display("FAIL rand_lit c=%0d: got %h want %h", c, out_lit, mq[0]); end
            end
            n_checks++; if (conflict !== m_c || conflict_var !== m_cv) begin n_fail++; $display("FAIL rand_conf c=%0d: c=%b cv=%h want %b/%h", c, conflict, conflict_var, m_c, m_cv); end
            if (flush) begin
                mq.delete(); m_rr = 0; m_last = -1; m_c = 1'b0; m_cv = '0;
            end else begin
                m_last = g ? w : -1;
                if (g) begin
                    lit_w = (w == 0) ? mem_lit : eng_lit[w-1];
                    hit = 1'b0;
                    for (int j = (pop_e ? 1 : 0); j < n; j++) begin
                        if (mq[j].vidx == lit_w[9:0] && mq[j].sign != lit_w[10]) hit = 1'b1;
                    end
                    if (EXP_C && hit && !m_c) begin m_c = 1'b1; m_cv = lit_w[9:0]; end
                end
                if (pop_e) void'(mq.pop_front());
                if (g) begin
                    mq.push_back(uc_pkg::lit_t'(lit_w));
                    m_rr = (w + 1) % 5;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full();
        test_mem_prio();
        test_flush();
        test_conflict();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
